dma_read_master: RTL and testbench
==================================

# dma_read_master

AXI4-Full read master for the Basys3 DMA. It fetches a contiguous source region in INCR bursts and pushes each returned beat into the shared data FIFO, which the write master drains. Bursts are capped at 64 bytes and never cross a 4 KB boundary. The FIFO full flag throttles the R channel.

## Interface
- C_M_AXI_ADDR_WIDTH, 32, AXI address width
- C_M_AXI_DATA_WIDTH, 32, AXI data width (only 32 supported)
- clk  in  1  system clock
- reset_n  in  1  reset; asynchronous, active-low
- i_start  in  1  start pulse, sampled only in IDLE
- i_src_addr  in  32  source byte address, word aligned
- i_total_len  in  32  transfer length in bytes; bits [1:0] ignored
- o_read_done  out  1  one-cycle pulse when the transfer completes
- i_fifo_full  in  1  data FIFO full
- o_fifo_wr_en  out  1  FIFO push strobe
- o_fifo_wdata  out  32  FIFO push data
- m_axi_araddr  out  ADDR_WIDTH  burst start address
- m_axi_arlen  out  8  beats minus 1
- m_axi_arsize  out  3  constant 3'b010
- m_axi_arburst  out  2  constant 2'b01 (INCR)
- m_axi_arvalid  out  1  address valid
- m_axi_arready  in  1  address ready
- m_axi_rdata  in  DATA_WIDTH  read data
- m_axi_rresp  in  2  read response
- m_axi_rlast  in  1  last beat
- m_axi_rvalid  in  1  data valid
- m_axi_rready  out  1  data ready
- o_read_err  out  1  sticky error flag; present only with DMA_RD_ERR_CHECK_EN

## Operation
- States, one-hot: IDLE, AR_PHASE, R_PHASE.
- Registers:
  - r_addr, r_remaining: 32-bit.
  - r_burst_bytes: 7-bit.
  - r_beat_cnt: 5-bit.
- Burst size is min(r_remaining, 64, 0x1000 − (r_addr & 0xFFF)) with bits [1:0] forced to 0.
- m_axi_arlen = r_burst_bytes[6:2] − 1.
- IDLE:
  - On i_start, latch i_src_addr and i_total_len & ~3.
  - If the latched length is 0: pulse o_read_done on the next cycle and stay in IDLE. No AR is issued.
  - Otherwise, enter AR_PHASE.
- AR_PHASE:
  - The burst size is registered on entry.
  - arvalid, araddr and arlen are registered and held stable until arready.
  - On handshake, go to R_PHASE.
- R_PHASE:
  - m_axi_rready = !i_fifo_full.
  - o_fifo_wr_en = rvalid && rready.
  - o_fifo_wdata = m_axi_rdata, combinational.
  - r_beat_cnt increments per beat.
- Burst end (RLAST handshake):
  - r_addr += r_burst_bytes; r_remaining −= r_burst_bytes.
  - If the new remaining value is nonzero, go to AR_PHASE; arvalid rises the next cycle.
  - Otherwise, go to IDLE and pulse o_read_done for one cycle.
- i_start is ignored outside IDLE.
- RLAST arriving early or late is not checked unless DMA_RD_ERR_CHECK_EN is defined. The burst ends on RLAST.

## Timing
- Reset values:
  - State IDLE.
  - arvalid, rready, o_fifo_wr_en, o_read_done, o_read_err: 0.
  - araddr, arlen: 0.
  - All internal counters: 0.
- i_start at cycle N → arvalid high at N+2 (cycle N+1 registers the burst size). An arready already high completes the handshake at N+2.
- AR handshake at cycle M → rready may assert at M+1.
- Final RLAST handshake at cycle K → o_read_done high in K+1 only.
- Back-to-back bursts: next arvalid at K+2.
- Full FIFO: rready is low in the same cycle i_fifo_full is high. No beat is lost or duplicated.
- Reset mid-burst: outputs return to reset values immediately. An outstanding AXI transaction is abandoned; the system must reset the slave as well.
- Address arithmetic is 32-bit and wraps modulo 2^32 without flagging.

## Configuration
- DMA_RD_ERR_CHECK_EN defined:
  - o_read_err exists and is sticky until the next accepted i_start.
  - It sets on rresp ≠ OKAY for any handshaked beat, or on an RLAST mismatch against r_beat_cnt.
  - On error, the current burst finishes and the block returns to IDLE. No further AR is issued and o_read_done still pulses.
- Not defined: the port is absent, rresp is ignored, and all bursts run to completion.

## Structure
- Package dma_pkg holds:
  - AXI constants: size 3'b010, burst INCR, RESP_OKAY.
  - DMA_MAX_BURST_BYTES = 64.
  - DMA_BOUNDARY = 4096.
  - State encodings.
- Sub-module dma_burst_calc computes burst bytes from (addr, remaining). It is combinational and shared with the write-side master.

## Test plan
- src=0x1000, len=16, ready always high → one AR: araddr 0x1000, arlen 3. Four FIFO pushes. Done pulse 1 cycle after the RLAST handshake.
- src=0x0, len=200 → four ARs:
  - araddr 0x00, 0x40, 0x80, 0xC0
  - arlen 15, 15, 15, 1
  - 50 pushes, data order preserved.
- src=0x0FF0, len=64 → split at 4 KB: AR 0x0FF0/arlen 3, then AR 0x1000/arlen 11.
- i_fifo_full high during beats 2–4 of a 4-beat burst → rready and wr_en low in those cycles. Exactly 4 pushes total with the correct data.
- len=3 (truncates to 0) → no arvalid; o_read_done high exactly one cycle.
- With DMA_RD_ERR_CHECK_EN, len=128, rresp=2'b10 on beat 1 of burst 0 → o_read_err=1, burst 0 completes, no second AR, done pulses.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared constants and state encoding for the DMA read/write masters.
package dma_pkg;

  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  localparam int unsigned DMA_MAX_BURST_BYTES = 64;
  localparam int unsigned DMA_BOUNDARY        = 4096;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'b001,
    ST_AR_PHASE = 3'b010,
    ST_R_PHASE  = 3'b100
  } dma_state_e;

endpackage

// File: rtl/dma_burst_calc.sv
// Burst length in bytes: min(remaining, 64, bytes to next 4 KB page), word multiple.
module dma_burst_calc
  import dma_pkg::*;
(
  input  logic [11:0] addr_lo,
  input  logic [31:0] remaining,
  output logic [6:0]  burst_bytes
);

  logic [12:0] to_boundary;
  logic [6:0]  limit;
  logic [6:0]  sel;

  always_comb begin
    to_boundary = 13'(DMA_BOUNDARY) - {1'b0, addr_lo};
    limit       = (to_boundary < 13'(DMA_MAX_BURST_BYTES)) ? to_boundary[6:0]
                                                          : 7'(DMA_MAX_BURST_BYTES);
    sel         = (remaining < {25'd0, limit}) ? remaining[6:0] : limit;
    burst_bytes = sel & 7'h7C;
  end

endmodule

// File: rtl/dma_read_master.sv
// AXI4 read master: fetches a contiguous region in INCR bursts into the data FIFO.
// Optional sticky response/RLAST error flag when DMA_RD_ERR_CHECK_EN is defined.
module dma_read_master
  import dma_pkg::*;
#(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          i_start,
  input  logic [31:0]                   i_src_addr,
  input  logic [31:0]                   i_total_len,
  output logic                          o_read_done,
  input  logic                          i_fifo_full,
  output logic                          o_fifo_wr_en,
  output logic [31:0]                   o_fifo_wdata,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]                    m_axi_arlen,
  output logic [2:0]                    m_axi_arsize,
  output logic [1:0]                    m_axi_arburst,
  output logic                          m_axi_arvalid,
  input  logic                          m_axi_arready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]                    m_axi_rresp,
  input  logic                          m_axi_rlast,
  input  logic                          m_axi_rvalid,
  output logic                          m_axi_rready
`ifdef DMA_RD_ERR_CHECK_EN
  ,
  output logic                          o_read_err
`endif
);

  dma_state_e                    state_q, state_d;
  logic [31:0]                   addr_q, addr_d;
  logic [31:0]                   remaining_q, remaining_d;
  logic [6:0]                    burst_bytes_q, burst_bytes_d;
  logic [4:0]                    beat_cnt_q, beat_cnt_d;
  logic                          arvalid_q, arvalid_d;
  logic [C_M_AXI_ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [7:0]                    arlen_q, arlen_d;
  logic                          done_q, done_d;

  logic [6:0] calc_bytes;
  logic       r_hs;
  logic       beat_err;
  logic       err_q;

  dma_burst_calc u_burst_calc (
    .addr_lo    (addr_q[11:0]),
    .remaining  (remaining_q),
    .burst_bytes(calc_bytes)
  );

  // R channel is throttled combinationally so a full FIFO never loses a beat.
  assign m_axi_rready  = (state_q == ST_R_PHASE) && !i_fifo_full;
  assign r_hs          = m_axi_rvalid && m_axi_rready;
  assign o_fifo_wr_en  = r_hs;
  assign o_fifo_wdata  = m_axi_rdata;
  assign m_axi_araddr  = araddr_q;
  assign m_axi_arlen   = arlen_q;
  assign m_axi_arsize  = AXI_SIZE_4B;
  assign m_axi_arburst = AXI_BURST_INCR;
  assign m_axi_arvalid = arvalid_q;
  assign o_read_done   = done_q;

`ifdef DMA_RD_ERR_CHECK_EN
  logic err_d;

  assign beat_err = r_hs && ((m_axi_rresp != AXI_RESP_OKAY) ||
                             (m_axi_rlast != (beat_cnt_q == arlen_q[4:0])));

  always_comb begin
    err_d = err_q;
    if (state_q == ST_IDLE && i_start) err_d = 1'b0;
    else if (beat_err)                 err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) err_q <= 1'b0;
    else          err_q <= err_d;
  end

  assign o_read_err = err_q;
`else
  logic unused_rd;

  assign beat_err  = 1'b0;
  assign err_q     = 1'b0;
  assign unused_rd = ^{m_axi_rresp, beat_cnt_q};
`endif

  // NOTE: every _d gets a default from its _q first, so no path leaves a latch.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    remaining_d   = remaining_q;
    burst_bytes_d = burst_bytes_q;
    beat_cnt_d    = beat_cnt_q;
    arvalid_d     = arvalid_q;
    araddr_d      = araddr_q;
    arlen_d       = arlen_q;
    done_d        = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          addr_d      = i_src_addr;
          remaining_d = {i_total_len[31:2], 2'b00};
          beat_cnt_d  = '0;
          if (i_total_len[31:2] == '0) done_d  = 1'b1;
          else                         state_d = ST_AR_PHASE;
        end
      end

      ST_AR_PHASE: begin
        // First cycle registers the burst; arvalid then holds until accepted.
        if (!arvalid_q) begin
          burst_bytes_d = calc_bytes;
          araddr_d      = addr_q[C_M_AXI_ADDR_WIDTH-1:0];
          arlen_d       = {3'd0, calc_bytes[6:2] - 5'd1};
          arvalid_d     = 1'b1;
        end else if (m_axi_arready) begin
          arvalid_d  = 1'b0;
          beat_cnt_d = '0;
          state_d    = ST_R_PHASE;
        end
      end

      ST_R_PHASE: begin
        if (r_hs) begin
          beat_cnt_d = beat_cnt_q + 5'd1;
          if (m_axi_rlast) begin
            addr_d      = addr_q + {25'd0, burst_bytes_q};
            remaining_d = remaining_q - {25'd0, burst_bytes_q};
            beat_cnt_d  = '0;
            if (remaining_d == '0 || err_q || beat_err) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = ST_AR_PHASE;
            end
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; next-state math stays in always_comb.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      addr_q        <= '0;
      remaining_q   <= '0;
      burst_bytes_q <= '0;
      beat_cnt_q    <= '0;
      arvalid_q     <= 1'b0;
      araddr_q      <= '0;
      arlen_q       <= '0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      remaining_q   <= remaining_d;
      burst_bytes_q <= burst_bytes_d;
      beat_cnt_q    <= beat_cnt_d;
      arvalid_q     <= arvalid_d;
      araddr_q      <= araddr_d;
      arlen_q       <= arlen_d;
      done_q        <= done_d;
    end
  end

endmodule

// File: tb/tb_dma_read_master.sv
// Randomized bench for dma_read_master: AXI slave/FIFO model plus a burst-splitting reference.
module tb_dma_read_master;

  logic        clk;
  logic        reset_n;
  logic        i_start;
  logic [31:0] i_src_addr;
  logic [31:0] i_total_len;
  logic        o_read_done;
  logic        i_fifo_full;
  logic        o_fifo_wr_en;
  logic [31:0] o_fifo_wdata;
  logic [31:0] m_axi_araddr;
  logic [7:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst;
  logic        m_axi_arvalid;
  logic        m_axi_arready;
  logic [31:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rlast;
  logic        m_axi_rvalid;
  logic        m_axi_rready;
`ifdef DMA_RD_ERR_CHECK_EN
  logic        o_read_err;
`endif

  dma_read_master dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_start      (i_start),
    .i_src_addr   (i_src_addr),
    .i_total_len  (i_total_len),
    .o_read_done  (o_read_done),
    .i_fifo_full  (i_fifo_full),
    .o_fifo_wr_en (o_fifo_wr_en),
    .o_fifo_wdata (o_fifo_wdata),
    .m_axi_araddr (m_axi_araddr),
    .m_axi_arlen  (m_axi_arlen),
    .m_axi_arsize (m_axi_arsize),
    .m_axi_arburst(m_axi_arburst),
    .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready),
    .m_axi_rdata  (m_axi_rdata),
    .m_axi_rresp  (m_axi_rresp),
    .m_axi_rlast  (m_axi_rlast),
    .m_axi_rvalid (m_axi_rvalid),
    .m_axi_rready (m_axi_rready)
`ifdef DMA_RD_ERR_CHECK_EN
    ,
    .o_read_err   (o_read_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'hA5A55A5A;
  endfunction

  // Slave/FIFO configuration (written by the test sequence only).
  int ar_pct = 100, rv_pct = 100, full_pct = 0;
  bit full_mode = 0, err_inject = 0;

  // Slave and monitor state (written by the monitor only).
  logic [31:0] rq_addr[$];
  logic [7:0]  rq_len[$];
  logic [31:0] obs_ar_addr[$];
  logic [7:0]  obs_ar_len[$];
  logic [31:0] obs_data[$];
  int beat = 0, burst_idx = 0, full_hold = 0;
  int cyc = 0, start_cyc = 0, first_arv_cyc = -1, last_rlast_cyc = -1;
  int done_cyc = -1, done_cnt = 0, viol = 0;
  bit rv_hold = 0, full_armed = 0, prev_ar_wait = 0;
  logic [31:0] prev_araddr = '0;
  logic [7:0]  prev_arlen = '0;

  // Drive slave inputs on the falling edge, observe settled handshakes 1 ns later.
  initial begin
    m_axi_arready = 1'b0;
    m_axi_rvalid  = 1'b0;
    m_axi_rdata   = '0;
    m_axi_rresp   = 2'b00;
    m_axi_rlast   = 1'b0;
    i_fifo_full   = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      m_axi_arready = ($urandom_range(0, 99) < ar_pct);
      if (full_hold > 0) begin
        i_fifo_full = 1'b1;
        full_hold--;
      end else begin
        i_fifo_full = ($urandom_range(0, 99) < full_pct);
      end
      if (rq_addr.size() > 0) begin
        m_axi_rvalid = rv_hold || ($urandom_range(0, 99) < rv_pct);
        m_axi_rdata  = mem_word(rq_addr[0] + 32'(4 * beat));
        m_axi_rlast  = (beat == int'(rq_len[0]));
        m_axi_rresp  = (err_inject && burst_idx == 0 && beat == 1) ? 2'b10 : 2'b00;
      end else begin
        m_axi_rvalid = 1'b0;
        m_axi_rlast  = 1'b0;
        m_axi_rresp  = 2'b00;
      end
      #1;
      if (i_start) begin
        start_cyc      = cyc;
        first_arv_cyc  = -1;
        last_rlast_cyc = -1;
        done_cyc       = -1;
        done_cnt       = 0;
        viol           = 0;
        burst_idx      = 0;
        full_armed     = full_mode;
        obs_ar_addr.delete();
        obs_ar_len.delete();
        obs_data.delete();
      end
      if (m_axi_arvalid && first_arv_cyc < 0) first_arv_cyc = cyc;
      if (prev_ar_wait && (!m_axi_arvalid || m_axi_araddr != prev_araddr ||
                           m_axi_arlen != prev_arlen)) viol++;
      prev_ar_wait = m_axi_arvalid && !m_axi_arready;
      prev_araddr  = m_axi_araddr;
      prev_arlen   = m_axi_arlen;
      if (i_fifo_full && m_axi_rready) viol++;
      if (o_fifo_wr_en !== (m_axi_rvalid && m_axi_rready)) viol++;
      if (m_axi_arvalid && m_axi_arready) begin
        obs_ar_addr.push_back(m_axi_araddr);
        obs_ar_len.push_back(m_axi_arlen);
        rq_addr.push_back(m_axi_araddr);
        rq_len.push_back(m_axi_arlen);
      end
      if (m_axi_rvalid && m_axi_rready) begin
        if (o_fifo_wr_en) obs_data.push_back(o_fifo_wdata);
        if (full_armed) begin
          full_hold  = 3;
          full_armed = 0;
        end
        rv_hold = 0;
        if (m_axi_rlast) begin
          last_rlast_cyc = cyc;
          void'(rq_addr.pop_front());
          void'(rq_len.pop_front());
          beat = 0;
          burst_idx++;
        end else begin
          beat++;
        end
      end else begin
        rv_hold = m_axi_rvalid;
      end
      if (o_read_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic run_xfer(input string tag, input logic [31:0] src, input logic [31:0] len,
                          input bit inj);
    logic [31:0] ea[$];
    logic [7:0]  el[$];
    logic [31:0] ed[$];
    logic [31:0] a, r, n, room;
    int          m;
    a = src;
    r = len & ~32'd3;
    while (r != 0) begin
      n    = (r > 32'd64) ? 32'd64 : r;
      room = 32'h1000 - (a & 32'hFFF);
      if (n > room) n = room;
      ea.push_back(a);
      el.push_back(8'(n / 4 - 1));
      for (int i = 0; i < int'(n / 4); i++) ed.push_back(mem_word(a + 32'(4 * i)));
      a += n;
      r -= n;
      if (inj) break;
    end

    err_inject = inj;
    @(negedge clk);
    i_src_addr  = src;
    i_total_len = len;
    i_start     = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    for (int k = 0; k < 5000 && done_cnt == 0; k++) @(negedge clk);
    repeat (4) @(negedge clk);

    check({tag, "_done_cnt"}, done_cnt, 1);
    if (ea.size() == 0) begin
      check({tag, "_done_lat"}, done_cyc - start_cyc, 1);
      check({tag, "_no_ar"}, first_arv_cyc, -1);
    end else begin
      check({tag, "_done_lat"}, done_cyc - last_rlast_cyc, 1);
      check({tag, "_arv_lat"}, first_arv_cyc - start_cyc, 2);
    end
    check({tag, "_ar_cnt"}, obs_ar_addr.size(), ea.size());
    m = (obs_ar_addr.size() < ea.size()) ? obs_ar_addr.size() : ea.size();
    for (int i = 0; i < m; i++) begin
      check($sformatf("%s_araddr%0d", tag, i), obs_ar_addr[i], ea[i]);
      check($sformatf("%s_arlen%0d", tag, i), obs_ar_len[i], el[i]);
    end
    check({tag, "_push_cnt"}, obs_data.size(), ed.size());
    m = (obs_data.size() < ed.size()) ? obs_data.size() : ed.size();
    for (int i = 0; i < m; i++) check($sformatf("%s_data%0d", tag, i), obs_data[i], ed[i]);
    check({tag, "_protocol"}, viol, 0);
`ifdef DMA_RD_ERR_CHECK_EN
    check({tag, "_err"}, o_read_err, inj);
`endif
    err_inject = 0;
  endtask

  initial begin
    logic [31:0] s;
    reset_n     = 1'b0;
    i_start     = 1'b0;
    i_src_addr  = '0;
    i_total_len = '0;
    repeat (3) @(negedge clk);
    check("rst_arvalid", m_axi_arvalid, 0);
    check("rst_rready", m_axi_rready, 0);
    check("rst_wr_en", o_fifo_wr_en, 0);
    check("rst_done", o_read_done, 0);
    check("rst_araddr", m_axi_araddr, 0);
    check("rst_arlen", m_axi_arlen, 0);
    check("arsize", m_axi_arsize, 3'b010);
    check("arburst", m_axi_arburst, 2'b01);
`ifdef DMA_RD_ERR_CHECK_EN
    check("rst_err", o_read_err, 0);
`endif
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    run_xfer("single", 32'h0000_1000, 32'd16, 0);
    run_xfer("multi", 32'h0000_0000, 32'd200, 0);
    run_xfer("split4k", 32'h0000_0FF0, 32'd64, 0);
    full_mode = 1;
    run_xfer("fifo_full", 32'h0000_2000, 32'd16, 0);
    full_mode = 0;
    run_xfer("zero_len", 32'h0000_3000, 32'd3, 0);
    run_xfer("wrap", 32'hFFFF_FFF0, 32'd32, 0);
`ifdef DMA_RD_ERR_CHECK_EN
    run_xfer("err", 32'h0000_0000, 32'd128, 1);
    run_xfer("err_clear", 32'h0000_0100, 32'd8, 0);
`endif

    for (int t = 0; t < 24; t++) begin
      ar_pct   = $urandom_range(30, 100);
      rv_pct   = $urandom_range(30, 100);
      full_pct = $urandom_range(0, 50);
      s        = $urandom;
      if ($urandom_range(0, 1) == 1) s[11:0] = 12'hF00 + 12'($urandom_range(0, 255));
      s[1:0] = 2'b00;
      run_xfer($sformatf("rand%0d", t), s, 32'($urandom_range(0, 300)), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
